ccu_timed: RTL and testbench
============================

# ccu_timed

Parametrised pedestrian-crossing control unit with an integrated phase timer. It sequences the walk → caution → hand light phases using per-phase durations set by parameters, so it needs no external timer/multiplier handshake. It adds a latched pedestrian request (optionally gating the hand phase) and a fault-driven flashing-orange mode. It sits between the pedestrian push-button/fault inputs and the lamp drivers.

## Interface
- TICK_DIV, 4: clock cycles per timer tick; ≥1
- CNT_W, 8: width of phase counter and `remaining`
- T_WALK, 6: walk duration in ticks; 1..2^CNT_W-1
- T_CAUTION, 3: caution duration in ticks; same range
- T_HAND, 8: minimum hand duration in ticks; same range
- FLASH_HALF, 2: ticks per half-period of the fault flash; same range
- REQ_MODE, 1: 1 = hand holds until a request is pending; 0 = free-running cycle

- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- req  in  1  pedestrian request, sampled every edge
- fault  in  1  level; forces flash mode while high
- green_walk  out  1  walk lamp
- orange_walk  out  1  caution / flash lamp
- red_hand  out  1  hand lamp
- phase  out  2  0 walk, 1 caution, 2 hand, 3 flash
- tr  out  1  high for exactly the first cycle of every phase entry
- remaining  out  CNT_W  ticks left in current phase or flash half-period
- req_pending  out  1  latched request

## Operation
- All outputs are registered and update on the same edge as `phase`.
- Reset (any edge with reset=1): phase=walk, green_walk=1, orange_walk=0, red_hand=0, tr=1, remaining=T_WALK, req_pending=0, prescaler=0. Reset mid-operation behaves identically and overrides fault and req.
- Prescaler: counts 0..TICK_DIV-1 and wraps. Internal tick = (prescaler==TICK_DIV-1). Prescaler is forced to 0 on every phase entry and on every flash half-period reload.
- Phase timer: loaded with the phase duration on entry. On a tick with remaining>1, it decrements. On a tick with remaining==1, the phase expires.
- Lamps: walk → green only. caution → orange only. hand → red only. flash → green=red=0, orange toggles.
- Transitions, in priority order:
  1. reset.
  2. fault=1 while not in flash → flash. orange=1, remaining=FLASH_HALF, req_pending cleared.
  3. In flash with fault=0 → hand. remaining=T_HAND.
  4. Timer expiry: walk → caution; caution → hand.
  5. hand with REQ_MODE=0: on expiry → walk.
  6. hand with REQ_MODE=1: exit to walk on a tick where (remaining==1 or remaining==0) and req_pending=1. If it expires with no pending request, remaining becomes 0 and hand holds.
- Flash: on a tick with remaining==1, orange toggles and remaining reloads FLASH_HALF. These toggles do not pulse tr.
- req_pending:
  - Set at an edge where req=1 and phase is caution or hand.
  - req is ignored in walk and flash.
  - Cleared at the edge entering walk or flash. A req at that same edge is discarded.
  - Set in the same cycle as a hand tick: the set is visible at that edge, but only a later tick can use it.
- Every entry into walk, caution, hand or flash loads `remaining` and raises tr for one cycle.

## Timing
- A phase of T ticks entered at cycle 0 produces ticks at cycles TICK_DIV-1, 2·TICK_DIV-1, …. The next phase is visible at cycle T·TICK_DIV, so the phase lasts exactly T·TICK_DIV cycles.
- Fault → flash latency: 1 cycle (visible the cycle after fault is sampled high). Flash → hand: likewise 1 cycle after fault is sampled low.
- Request-gated exit from a held hand: walk becomes visible at most TICK_DIV+1 cycles after req is sampled.
- Free-running period (REQ_MODE=0): (T_WALK+T_CAUTION+T_HAND)·TICK_DIV cycles.

## Test plan
Bench parameters: TICK_DIV=2, T_WALK=3, T_CAUTION=2, T_HAND=4, FLASH_HALF=2, REQ_MODE=1.
- Release reset, req=0 → walk for cycles 0–5, caution for 6–9, hand from 10. tr=1 at cycles 0, 6 and 10 only. From cycle 18, hand holds with remaining=0 indefinitely.
- During the held hand, pulse req for 1 cycle → req_pending=1 next cycle. Walk is entered within 3 cycles with tr=1, and req_pending=0.
- Pulse req during walk → ignored. Pulse req during caution → latched; hand lasts exactly 8 cycles, then walk.
- Raise fault mid-caution → next cycle phase=3, tr=1, orange=1. orange toggles every 4 cycles. Drop fault → next cycle hand, remaining=4, red=1.
- Assert reset for 1 cycle mid-hand → next cycle walk, green=1, tr=1, remaining=3, req_pending=0.
- REQ_MODE=0, req=0 → free-running with walk entries every 18 cycles and lamp sequence green/orange/red.

Source files
------------

// File: rtl/ccu_timed.sv
// ccu_timed: pedestrian-crossing control unit with a built-in phase timer.
//
// Cycles walk -> caution -> hand using tick-based durations set by
// parameters. A prescaler divides the clock into timer ticks. A latched
// pedestrian request can gate the exit from hand (REQ_MODE=1). While fault
// is high the unit flashes the orange lamp.
//
// Ports:
//   clk_i          clock, all state on posedge
//   reset_i        synchronous, active-high reset
//   req_i          pedestrian request, sampled every edge
//   fault_i        level fault input, forces flash mode while high
//   green_walk_o   walk lamp
//   orange_walk_o  caution / flash lamp
//   red_hand_o     hand lamp
//   phase_o        0 walk, 1 caution, 2 hand, 3 flash
//   tr_o           high for the first cycle of every phase entry
//   remaining_o    ticks left in the phase or the flash half-period
//   req_pending_o  latched pedestrian request
//
// Every output comes straight from a register, so all outputs change on the
// same edge as phase_o.
module ccu_timed #(
  parameter int unsigned TICK_DIV   = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned T_WALK     = 6,
  parameter int unsigned T_CAUTION  = 3,
  parameter int unsigned T_HAND     = 8,
  parameter int unsigned FLASH_HALF = 2,
  parameter int unsigned REQ_MODE   = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_i,
  input  logic             fault_i,
  output logic             green_walk_o,
  output logic             orange_walk_o,
  output logic             red_hand_o,
  output logic [1:0]       phase_o,
  output logic             tr_o,
  output logic [CNT_W-1:0] remaining_o,
  output logic             req_pending_o
);

  // A prescaler of at least one bit keeps TICK_DIV=1 legal. The tick then
  // fires on every cycle.
  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);

  localparam logic [CNT_W-1:0] DurWalk    = CNT_W'(T_WALK);
  localparam logic [CNT_W-1:0] DurCaution = CNT_W'(T_CAUTION);
  localparam logic [CNT_W-1:0] DurHand    = CNT_W'(T_HAND);
  localparam logic [CNT_W-1:0] DurFlash   = CNT_W'(FLASH_HALF);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  localparam bit ReqGate = (REQ_MODE != 0);

  typedef enum logic [1:0] {
    StWalk    = 2'd0,
    StCaution = 2'd1,
    StHand    = 2'd2,
    StFlash   = 2'd3
  } phase_e;

  phase_e           phase_q, phase_d;
  logic [PreW-1:0]  pre_q, pre_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             tr_q, tr_d;
  logic             pend_q, pend_d;
  logic             green_q, green_d;
  logic             orange_q, orange_d;
  logic             red_q, red_d;

  logic             tick;
  logic             rem_one;
  logic             rem_le_one;
  logic             do_entry;
  phase_e           entry;

  assign tick       = (pre_q == PreMax);
  assign rem_one    = (rem_q == CntOne);
  assign rem_le_one = (rem_q <= CntOne);

  // Transition decision. do_entry/entry name the phase being entered; the
  // entry side effects (timer load, tr pulse, lamps, prescaler clear) are
  // applied in one place below so every phase entry behaves identically.
  always_comb begin
    do_entry = 1'b0;
    entry    = StWalk;

    phase_d  = phase_q;
    pre_d    = tick ? '0 : pre_q + PreW'(1);
    rem_d    = rem_q;
    tr_d     = 1'b0;
    green_d  = green_q;
    orange_d = orange_q;
    red_d    = red_q;
    // Requests only latch while the hand phase is upcoming or active.
    pend_d   = pend_q | (req_i & ((phase_q == StCaution) | (phase_q == StHand)));

    if (fault_i && (phase_q != StFlash)) begin
      do_entry = 1'b1;
      entry    = StFlash;
    end else begin
      unique case (phase_q)
        StFlash: begin
          if (!fault_i) begin
            do_entry = 1'b1;
            entry    = StHand;
          end else if (tick) begin
            if (rem_one) begin
              // Half-period reload: toggles orange without a tr pulse.
              orange_d = ~orange_q;
              rem_d    = DurFlash;
              pre_d    = '0;
            end else begin
              rem_d = rem_q - CntOne;
            end
          end
        end

        StWalk: begin
          if (tick) begin
            if (rem_one) begin
              do_entry = 1'b1;
              entry    = StCaution;
            end else begin
              rem_d = rem_q - CntOne;
            end
          end
        end

        StCaution: begin
          if (tick) begin
            if (rem_one) begin
              do_entry = 1'b1;
              entry    = StHand;
            end else begin
              rem_d = rem_q - CntOne;
            end
          end
        end

        StHand: begin
          if (tick) begin
            if (ReqGate) begin
              // Uses the request latched before this edge; a request set
              // on this same tick waits for the next one.
              if (rem_le_one && pend_q) begin
                do_entry = 1'b1;
                entry    = StWalk;
              end else if (rem_le_one) begin
                // Expired with no request: park at zero and hold.
                rem_d = '0;
              end else begin
                rem_d = rem_q - CntOne;
              end
            end else begin
              if (rem_one) begin
                do_entry = 1'b1;
                entry    = StWalk;
              end else begin
                rem_d = rem_q - CntOne;
              end
            end
          end
        end

        default: ;
      endcase
    end

    if (do_entry) begin
      phase_d = entry;
      tr_d    = 1'b1;
      pre_d   = '0;
      unique case (entry)
        StWalk: begin
          rem_d    = DurWalk;
          green_d  = 1'b1;
          orange_d = 1'b0;
          red_d    = 1'b0;
          // Entering walk discards any request, including one on this edge.
          pend_d   = 1'b0;
        end
        StCaution: begin
          rem_d    = DurCaution;
          green_d  = 1'b0;
          orange_d = 1'b1;
          red_d    = 1'b0;
        end
        StHand: begin
          rem_d    = DurHand;
          green_d  = 1'b0;
          orange_d = 1'b0;
          red_d    = 1'b1;
        end
        StFlash: begin
          rem_d    = DurFlash;
          green_d  = 1'b0;
          orange_d = 1'b1;
          red_d    = 1'b0;
          pend_d   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Single state register for the whole controller. Reset wins over fault
  // and req.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      phase_q  <= StWalk;
      pre_q    <= '0;
      rem_q    <= DurWalk;
      tr_q     <= 1'b1;
      pend_q   <= 1'b0;
      green_q  <= 1'b1;
      orange_q <= 1'b0;
      red_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      pre_q    <= pre_d;
      rem_q    <= rem_d;
      tr_q     <= tr_d;
      pend_q   <= pend_d;
      green_q  <= green_d;
      orange_q <= orange_d;
      red_q    <= red_d;
    end
  end

  assign green_walk_o  = green_q;
  assign orange_walk_o = orange_q;
  assign red_hand_o    = red_q;
  assign phase_o       = phase_q;
  assign tr_o          = tr_q;
  assign remaining_o   = rem_q;
  assign req_pending_o = pend_q;

endmodule

// File: tb/tb_ccu_timed.sv
// Testbench for ccu_timed: two instances share the inputs, one request-gated
// (REQ_MODE=1) and one free-running (REQ_MODE=0). Both are compared each
// cycle against a reference model that tracks only the phase and the number
// of cycles spent in it, deriving the timer and lamps arithmetically.
module tb_ccu_timed;

  localparam int TD = 2;
  localparam int TW = 3;
  localparam int TC = 2;
  localparam int TH = 4;
  localparam int FH = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req = 1'b0;
  logic fault = 1'b0;

  logic       d_green[2];
  logic       d_orange[2];
  logic       d_red[2];
  logic [1:0] d_phase[2];
  logic       d_tr[2];
  logic [7:0] d_rem[2];
  logic       d_pend[2];

  int n_chk = 0;
  int n_bad = 0;

  // Model state: phase (0..3), cycles since phase entry, latched request.
  int m_phase[2];
  int m_age[2];
  bit m_pend[2];

  always #5 clk = ~clk;

  ccu_timed #(
    .TICK_DIV(TD), .CNT_W(8), .T_WALK(TW), .T_CAUTION(TC), .T_HAND(TH),
    .FLASH_HALF(FH), .REQ_MODE(1)
  ) u_dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .fault_i(fault),
    .green_walk_o(d_green[0]), .orange_walk_o(d_orange[0]), .red_hand_o(d_red[0]),
    .phase_o(d_phase[0]), .tr_o(d_tr[0]), .remaining_o(d_rem[0]),
    .req_pending_o(d_pend[0])
  );

  ccu_timed #(
    .TICK_DIV(TD), .CNT_W(8), .T_WALK(TW), .T_CAUTION(TC), .T_HAND(TH),
    .FLASH_HALF(FH), .REQ_MODE(0)
  ) u_dut_free (
    .clk_i(clk), .reset_i(reset), .req_i(req), .fault_i(fault),
    .green_walk_o(d_green[1]), .orange_walk_o(d_orange[1]), .red_hand_o(d_red[1]),
    .phase_o(d_phase[1]), .tr_o(d_tr[1]), .remaining_o(d_rem[1]),
    .req_pending_o(d_pend[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int dur(input int ph);
    case (ph)
      0:       return TW;
      1:       return TC;
      default: return TH;
    endcase
  endfunction

  function automatic int exp_rem(input int i);
    int r;
    if (m_phase[i] == 3) return FH - (m_age[i] % (FH * TD)) / TD;
    r = dur(m_phase[i]) - m_age[i] / TD;
    return (r < 0) ? 0 : r;
  endfunction

  function automatic int exp_orange(input int i);
    if (m_phase[i] == 1) return 1;
    if (m_phase[i] == 3) return ((m_age[i] / (FH * TD)) % 2 == 0) ? 1 : 0;
    return 0;
  endfunction

  // Advance model i by one clock edge with the given inputs.
  task automatic model_step(input int i, input bit rq, input bit ft, input bit rs);
    bit tick;
    bit new_pend;
    int left;
    int nph;
    int nage;
    if (rs) begin
      m_phase[i] = 0;
      m_age[i]   = 0;
      m_pend[i]  = 1'b0;
      return;
    end
    tick     = (m_age[i] % TD) == TD - 1;
    new_pend = m_pend[i] | (rq && (m_phase[i] == 1 || m_phase[i] == 2));
    nph      = m_phase[i];
    nage     = m_age[i] + 1;
    left     = dur(m_phase[i]) - m_age[i] / TD;
    if (ft && m_phase[i] != 3) begin
      nph = 3; nage = 0; new_pend = 1'b0;
    end else if (m_phase[i] == 3) begin
      if (!ft) begin
        nph = 2; nage = 0;
      end
    end else if (tick) begin
      if (m_phase[i] < 2) begin
        if (left == 1) begin
          nph = m_phase[i] + 1; nage = 0;
        end
      end else if ((i == 0) ? (left <= 1 && m_pend[i]) : (left == 1)) begin
        nph = 0; nage = 0; new_pend = 1'b0;
      end
    end
    m_phase[i] = nph;
    m_age[i]   = nage;
    m_pend[i]  = new_pend;
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("u%0d.phase", i), 32'(d_phase[i]), 32'(m_phase[i]));
      check_eq($sformatf("u%0d.remaining", i), 32'(d_rem[i]), 32'(exp_rem(i)));
      check_eq($sformatf("u%0d.tr", i), 32'(d_tr[i]), 32'(m_age[i] == 0));
      check_eq($sformatf("u%0d.req_pending", i), 32'(d_pend[i]), 32'(m_pend[i]));
      check_eq($sformatf("u%0d.green", i), 32'(d_green[i]), 32'(m_phase[i] == 0));
      check_eq($sformatf("u%0d.orange", i), 32'(d_orange[i]), 32'(exp_orange(i)));
      check_eq($sformatf("u%0d.red", i), 32'(d_red[i]), 32'(m_phase[i] == 2));
    end
  endtask

  task automatic finish_up();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  endtask

  // Drive inputs, clock one edge, step both models, sample #1 after the edge.
  task automatic run_cycle(input bit rq, input bit ft, input bit rs);
    req   = rq;
    fault = ft;
    reset = rs;
    @(posedge clk);
    model_step(0, rq, ft, rs);
    model_step(1, rq, ft, rs);
    #1;
    compare_all();
    if (n_bad > 40) finish_up();
  endtask

  initial begin
    bit seen;
    bit fst;

    // Reset, then idle: walk 0-5, caution 6-9, hand from 10, held from 18.
    run_cycle(0, 0, 1);
    check_eq("rst.phase", 32'(d_phase[0]), 0);
    check_eq("rst.remaining", 32'(d_rem[0]), TW);
    check_eq("rst.tr", 32'(d_tr[0]), 1);
    check_eq("rst.green", 32'(d_green[0]), 1);
    for (int k = 1; k <= 24; k++) begin
      run_cycle(0, 0, 0);
      if (k == 6) begin
        check_eq("c6.phase", 32'(d_phase[0]), 1);
        check_eq("c6.tr", 32'(d_tr[0]), 1);
      end
      if (k == 10) begin
        check_eq("c10.phase", 32'(d_phase[0]), 2);
        check_eq("c10.tr", 32'(d_tr[0]), 1);
      end
      if (k == 18) begin
        check_eq("c18.remaining", 32'(d_rem[0]), 0);
        check_eq("free.c18.phase", 32'(d_phase[1]), 0);
        check_eq("free.c18.tr", 32'(d_tr[1]), 1);
      end
      if (k == 24) begin
        check_eq("hold.phase", 32'(d_phase[0]), 2);
        check_eq("hold.remaining", 32'(d_rem[0]), 0);
      end
    end

    // Request during the held hand releases it to walk within 3 cycles.
    run_cycle(1, 0, 0);
    check_eq("req.latched", 32'(d_pend[0]), 1);
    seen = 1'b0;
    for (int j = 0; j < 3; j++) begin
      run_cycle(0, 0, 0);
      if (d_phase[0] == 2'd0) begin
        seen = 1'b1;
        check_eq("req.walk_tr", 32'(d_tr[0]), 1);
        check_eq("req.walk_pend", 32'(d_pend[0]), 0);
        break;
      end
    end
    check_eq("req.walk_reached", 32'(seen), 1);

    // Fault mid-caution, hold it, then release into hand.
    run_cycle(0, 0, 1);
    for (int k = 0; k < 7; k++) run_cycle(0, 0, 0);
    run_cycle(0, 1, 0);
    check_eq("flt.phase", 32'(d_phase[0]), 3);
    check_eq("flt.tr", 32'(d_tr[0]), 1);
    check_eq("flt.orange", 32'(d_orange[0]), 1);
    for (int k = 0; k < 9; k++) run_cycle(0, 1, 0);
    run_cycle(0, 0, 0);
    check_eq("unflt.phase", 32'(d_phase[0]), 2);
    check_eq("unflt.remaining", 32'(d_rem[0]), TH);
    check_eq("unflt.red", 32'(d_red[0]), 1);

    // Reset mid-hand with a request pending.
    run_cycle(1, 0, 0);
    run_cycle(1, 0, 1);
    check_eq("rst2.phase", 32'(d_phase[0]), 0);
    check_eq("rst2.remaining", 32'(d_rem[0]), TW);
    check_eq("rst2.pend", 32'(d_pend[0]), 0);

    // Randomized traffic: sparse requests, fault bursts, occasional reset.
    fst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!fst) fst = ($urandom_range(0, 79) == 0);
      else      fst = !($urandom_range(0, 11) == 0);
      run_cycle($urandom_range(0, 9) == 0, fst, $urandom_range(0, 399) == 0);
    end

    finish_up();
  end

endmodule
